l1_mem_port_arbiter: RTL and testbench

- Shares the single cache-line memory port among N L1-side clients: l1d, l1i, and a future page-table walker.
- Replaces the ad-hoc two-way arbiter in the core top level with a parameterised round-robin scheduler.
- Latches single-cycle request pulses and holds one request outstanding on the memory port until its response.
- Routes each response pulse back to the client that owns it.

---
 rtl/l1_mem_port_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_l1_mem_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : l1_mem_port_arbiter
//  Description : Round-robin arbiter sharing one cache-line memory port among
//                N L1-side clients (0 = l1d, 1 = l1i, 2 = ptw). Latches
//                request pulses, keeps one request outstanding on the memory
//                port and routes each response back to its owner.
//                Optional MEM_ARB_STATS_EN adds per-client grant and
//                wait-cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module l1_mem_port_arbiter #(
    parameter int N_CLIENTS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int TAG_W     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hold_off,
    input  logic [N_CLIENTS-1:0]          cl_req_valid,
    input  logic [N_CLIENTS*ADDR_W-1:0]   cl_req_addr,
    input  logic [N_CLIENTS*DATA_W-1:0]   cl_req_store_data,
    input  logic [N_CLIENTS*TAG_W-1:0]    cl_req_tag,
    input  logic [N_CLIENTS*4-1:0]        cl_req_opcode,
    output logic [N_CLIENTS-1:0]          cl_rsp_valid,
    output logic [DATA_W-1:0]             cl_rsp_load_data,
    output logic                          mem_req_valid,
    output logic [ADDR_W-1:0]             mem_req_addr,
    output logic [DATA_W-1:0]             mem_req_store_data,
    output logic [TAG_W-1:0]              mem_req_tag,
    output logic [3:0]                    mem_req_opcode,
    input  logic                          mem_rsp_valid,
    input  logic [DATA_W-1:0]             mem_rsp_load_data,
    output logic                          arb_idle,
    output logic                          spurious_rsp
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [N_CLIENTS*32-1:0]       arb_grant_count,
    output logic [N_CLIENTS*32-1:0]       arb_wait_cycles
`endif
);

    localparam int          c_idx_w   = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam logic [0:0]  c_st_idle = 1'b0;
    localparam logic [0:0]  c_st_busy = 1'b1;
    localparam logic [c_idx_w-1:0] c_last_init = c_idx_w'(N_CLIENTS - 1);

    logic [0:0]             r_state;
    logic [0:0]             w_state_next;
    logic [N_CLIENTS-1:0]   r_pend;
    logic [N_CLIENTS-1:0]   w_eligible;
    logic [N_CLIENTS-1:0]   w_owner_mask;
    logic [N_CLIENTS-1:0]   w_new_req;
    logic [N_CLIENTS-1:0]   w_grant_mask;
    logic [c_idx_w-1:0]     r_owner;
    logic [c_idx_w-1:0]     r_last_gnt;
    logic [c_idx_w-1:0]     w_grant_idx;
    logic                   w_grant_found;
    logic                   w_grant_fire;
    logic                   r_spurious;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_data;
    logic [TAG_W-1:0]       w_sel_tag;
    logic [3:0]             w_sel_opcode;
    logic [ADDR_W-1:0]      r_req_addr;
    logic [DATA_W-1:0]      r_req_data;
    logic [TAG_W-1:0]       r_req_tag;
    logic [3:0]             r_req_opcode;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> BUSY on a grant, BUSY -> IDLE on a response
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_grant_fire)  w_state_next = c_st_busy;
            c_st_busy: if (mem_rsp_valid) w_state_next = c_st_idle;
            default:                      w_state_next = c_st_idle;
        endcase
    end

    // FSM outputs: port level, owner-routed response pulse, idle indication
    always_comb begin
        mem_req_valid = (r_state == c_st_busy);
        cl_rsp_valid  = (r_state == c_st_busy && mem_rsp_valid) ? w_owner_mask : '0;
        arb_idle      = (r_state == c_st_idle) && (r_pend == '0);
    end

    // Round-robin pick: first eligible index above last_gnt, then wrap to the bottom
    always_comb begin
        w_eligible    = r_pend | cl_req_valid;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (!w_grant_found && w_eligible[i] && (c_idx_w'(i) > r_last_gnt)) begin
                w_grant_found = 1'b1;
                w_grant_idx   = c_idx_w'(i);
            end
        end
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (!w_grant_found && w_eligible[i]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = c_idx_w'(i);
            end
        end
        w_grant_fire = (r_state == c_st_idle) && !hold_off && w_grant_found;
        for (int i = 0; i < N_CLIENTS; i++) begin
            w_owner_mask[i] = (r_state == c_st_busy) && (r_owner == c_idx_w'(i));
            w_grant_mask[i] = w_grant_fire && (w_grant_idx == c_idx_w'(i));
        end
        // The current owner cannot queue a second request behind itself
        w_new_req = cl_req_valid & ~w_owner_mask;
    end

    // Select the winning client's request fields
    always_comb begin
        w_sel_addr   = '0;
        w_sel_data   = '0;
        w_sel_tag    = '0;
        w_sel_opcode = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (w_grant_idx == c_idx_w'(i)) begin
                w_sel_addr   = cl_req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data   = cl_req_store_data[i*DATA_W +: DATA_W];
                w_sel_tag    = cl_req_tag[i*TAG_W +: TAG_W];
                w_sel_opcode = cl_req_opcode[i*4 +: 4];
            end
        end
    end

    // Pending bits: set by pulses, cleared when granted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend | w_new_req) & ~w_grant_mask;
        end
    end

    // Memory request registers, owner and round-robin pointer, loaded at grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_addr   <= '0;
            r_req_data   <= '0;
            r_req_tag    <= '0;
            r_req_opcode <= '0;
            r_owner      <= '0;
            r_last_gnt   <= c_last_init;
        end else if (w_grant_fire) begin
            r_req_addr   <= w_sel_addr;
            r_req_data   <= w_sel_data;
            r_req_tag    <= w_sel_tag;
            r_req_opcode <= w_sel_opcode;
            r_owner      <= w_grant_idx;
            r_last_gnt   <= w_grant_idx;
        end
    end

    // Sticky flag for responses arriving with nothing outstanding; those are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_spurious <= 1'b0;
        end else if (r_state == c_st_idle && mem_rsp_valid) begin
            r_spurious <= 1'b1;
        end
    end

    assign mem_req_addr       = r_req_addr;
    assign mem_req_store_data = r_req_data;
    assign mem_req_tag        = r_req_tag;
    assign mem_req_opcode     = r_req_opcode;
    assign cl_rsp_load_data   = mem_rsp_load_data;
    assign spurious_rsp       = r_spurious;

`ifdef MEM_ARB_STATS_EN
    for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_stats
        logic [31:0] r_grant_cnt;
        logic [31:0] r_wait_cnt;

        // Per-client grant and pending-cycle counters, wrapping at 2^32
        always_ff @(posedge clk) begin
            if (reset) begin
                r_grant_cnt <= '0;
                r_wait_cnt  <= '0;
            end else begin
                if (w_grant_mask[gi]) r_grant_cnt <= r_grant_cnt + 32'd1;
                if (r_pend[gi])       r_wait_cnt  <= r_wait_cnt + 32'd1;
            end
        end

        assign arb_grant_count[gi*32 +: 32] = r_grant_cnt;
        assign arb_wait_cycles[gi*32 +: 32] = r_wait_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_l1_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l1_mem_port_arbiter
//  Description : Self-checking bench for l1_mem_port_arbiter: directed
//                scenarios plus randomized traffic against a transaction-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_mem_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int TW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            hold_off;
    logic [N-1:0]    cl_req_valid;
    logic [N*AW-1:0] cl_req_addr;
    logic [N*DW-1:0] cl_req_store_data;
    logic [N*TW-1:0] cl_req_tag;
    logic [N*4-1:0]  cl_req_opcode;
    logic [N-1:0]    cl_rsp_valid;
    logic [DW-1:0]   cl_rsp_load_data;
    logic            mem_req_valid;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_store_data;
    logic [TW-1:0]   mem_req_tag;
    logic [3:0]      mem_req_opcode;
    logic            mem_rsp_valid;
    logic [DW-1:0]   mem_rsp_load_data;
    logic            arb_idle;
    logic            spurious_rsp;
`ifdef MEM_ARB_STATS_EN
    logic [N*32-1:0] arb_grant_count;
    logic [N*32-1:0] arb_wait_cycles;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: set of waiting clients, the request in flight, round-robin pointer
    bit            m_pend [N];
    bit            m_busy;
    int            m_owner;
    int            m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [TW-1:0] m_tag;
    logic [3:0]    m_op;
    bit            m_spur;
    int unsigned   m_gcnt [N];
    int unsigned   m_wcnt [N];

    l1_mem_port_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk                (clk),
        .reset              (reset),
        .hold_off           (hold_off),
        .cl_req_valid       (cl_req_valid),
        .cl_req_addr        (cl_req_addr),
        .cl_req_store_data  (cl_req_store_data),
        .cl_req_tag         (cl_req_tag),
        .cl_req_opcode      (cl_req_opcode),
        .cl_rsp_valid       (cl_rsp_valid),
        .cl_rsp_load_data   (cl_rsp_load_data),
        .mem_req_valid      (mem_req_valid),
        .mem_req_addr       (mem_req_addr),
        .mem_req_store_data (mem_req_store_data),
        .mem_req_tag        (mem_req_tag),
        .mem_req_opcode     (mem_req_opcode),
        .mem_rsp_valid      (mem_rsp_valid),
        .mem_rsp_load_data  (mem_rsp_load_data),
        .arb_idle           (arb_idle),
        .spurious_rsp       (spurious_rsp)
`ifdef MEM_ARB_STATS_EN
        ,
        .arb_grant_count    (arb_grant_count),
        .arb_wait_cycles    (arb_wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Advance the model by one clock using the inputs presented this cycle
    task automatic model_step();
        int pick;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_gcnt[i] = 0; m_wcnt[i] = 0;
            end
            m_busy = 0; m_owner = 0; m_last = N - 1; m_spur = 0;
            m_addr = '0; m_data = '0; m_tag = '0; m_op = '0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (cl_req_valid[i] && (m_pend[i] || (m_busy && m_owner == i))) begin
                $display("FAIL illegal_pulse client=%0d got=pulse expected=no_pulse", i);
                $fatal(1, "illegal request pulse");
            end
            if (m_pend[i]) m_wcnt[i]++;
        end
        if (m_busy) begin
            for (int i = 0; i < N; i++)
                if (cl_req_valid[i] && i != m_owner) m_pend[i] = 1;
            if (mem_rsp_valid) m_busy = 0;
        end else begin
            if (mem_rsp_valid) m_spur = 1;
            pick = -1;
            if (!hold_off) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (pick < 0 && (m_pend[c] || cl_req_valid[c])) pick = c;
                end
            end
            for (int i = 0; i < N; i++)
                if (cl_req_valid[i]) m_pend[i] = 1;
            if (pick >= 0) begin
                m_pend[pick] = 0;
                m_busy  = 1;
                m_owner = pick;
                m_last  = pick;
                m_addr  = cl_req_addr[pick*AW +: AW];
                m_data  = cl_req_store_data[pick*DW +: DW];
                m_tag   = cl_req_tag[pick*TW +: TW];
                m_op    = cl_req_opcode[pick*4 +: 4];
                m_gcnt[pick]++;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_client(input int i, input logic [AW-1:0] a, input logic [TW-1:0] t,
                              input logic [3:0] o);
        cl_req_addr[i*AW +: AW]       = a;
        cl_req_store_data[i*DW +: DW] = rand_line();
        cl_req_tag[i*TW +: TW]        = t;
        cl_req_opcode[i*4 +: 4]       = o;
        cl_req_valid[i]               = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1; hold_off = 1'b0; cl_req_valid = '0; mem_rsp_valid = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; hold_off = 1'b0; cl_req_valid = '0; mem_rsp_valid = 1'b0;
        cl_req_addr = '0; cl_req_store_data = '0; cl_req_tag = '0; cl_req_opcode = '0;
        mem_rsp_load_data = '0;
        next_cycle();
        next_cycle();
        #1;
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b expected=0", mem_req_valid); end
        total++; if ({mem_req_addr, mem_req_tag, mem_req_opcode} !== '0) begin bad++; $display("FAIL reset_fields got=%h expected=0", {mem_req_addr, mem_req_tag, mem_req_opcode}); end
        total++; if (mem_req_store_data !== '0) begin bad++; $display("FAIL reset_data got=%h expected=0", mem_req_store_data); end
        total++; if (cl_rsp_valid !== 3'b000) begin bad++; $display("FAIL reset_rsp got=%b expected=000", cl_rsp_valid); end
        total++; if (arb_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b expected=1", arb_idle); end
        total++; if (spurious_rsp !== 1'b0) begin bad++; $display("FAIL reset_spur got=%b expected=0", spurious_rsp); end
        reset = 1'b0;
    endtask

    task automatic test_single_request();
        logic [DW-1:0] sd, rd;
        do_reset();
        set_client(1, 32'h1000, 2'd2, 4'd4);
        sd = cl_req_store_data[1*DW +: DW];
        next_cycle();
        cl_req_valid = '0;
        #1;
        total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b expected=1", mem_req_valid); end
        total++; if (mem_req_addr !== 32'h1000) begin bad++; $display("FAIL single_addr got=%h expected=1000", mem_req_addr); end
        total++; if (mem_req_tag !== 2'd2 || mem_req_opcode !== 4'd4) begin bad++; $display("FAIL single_tag_op got=%0d/%0d expected=2/4", mem_req_tag, mem_req_opcode); end
        total++; if (mem_req_store_data !== sd) begin bad++; $display("FAIL single_data got=%h expected=%h", mem_req_store_data, sd); end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000) begin bad++; $display("FAIL single_hold got=%b/%h expected=1/1000", mem_req_valid, mem_req_addr); end
        end
        rd = rand_line();
        mem_rsp_valid = 1'b1; mem_rsp_load_data = rd;
        #1;
        total++; if (cl_rsp_valid !== 3'b010) begin bad++; $display("FAIL single_rsp got=%b expected=010", cl_rsp_valid); end
        total++; if (cl_rsp_load_data !== rd) begin bad++; $display("FAIL single_load got=%h expected=%h", cl_rsp_load_data, rd); end
        next_cycle();
        mem_rsp_valid = 1'b0;
        #1;
        total++; if (mem_req_valid !== 1'b0 || cl_rsp_valid !== 3'b000) begin bad++; $display("FAIL single_drop got=%b/%b expected=0/000", mem_req_valid, cl_rsp_valid); end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_rsp;
        int waited;
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < N; i++)
                set_client(i, 32'hA000 + 32'(i + rep * 16), TW'(i), 4'(i + 1));
            next_cycle();
            cl_req_valid = '0;
            for (int g = 0; g < N; g++) begin
                waited = 0;
                while (!mem_req_valid && waited < 10) begin next_cycle(); waited++; end
                total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL contention_timeout got=%b expected=1", mem_req_valid); end
                total++; if (mem_req_addr !== 32'hA000 + 32'(g + rep * 16)) begin bad++; $display("FAIL contention_order rep=%0d got=%h expected=%h", rep, mem_req_addr, 32'hA000 + 32'(g + rep * 16)); end
                next_cycle();
                mem_rsp_valid = 1'b1; mem_rsp_load_data = rand_line();
                exp_rsp = 3'b001 << g;
                #1;
                total++; if (cl_rsp_valid !== exp_rsp) begin bad++; $display("FAIL contention_rsp got=%b expected=%b", cl_rsp_valid, exp_rsp); end
                next_cycle();
                mem_rsp_valid = 1'b0;
                #1;
                total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL contention_gap got=%b expected=0", mem_req_valid); end
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        set_client(0, 32'hB000, 2'd0, 4'd1);
        set_client(2, 32'hB002, 2'd2, 4'd3);
        next_cycle();
        cl_req_valid = '0;
        #1;
        total++; if (mem_req_addr !== 32'hB000) begin bad++; $display("FAIL fair_first got=%h expected=b000", mem_req_addr); end
        next_cycle();
        mem_rsp_valid = 1'b1;
        next_cycle();
        mem_rsp_valid = 1'b0;
        set_client(0, 32'hB100, 2'd1, 4'd5);
        #1;
        total++; if (arb_idle !== 1'b0 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL fair_idle got=%b/%b expected=0/0", arb_idle, mem_req_valid); end
        next_cycle();
        cl_req_valid = '0;
        #1;
        total++; if (mem_req_addr !== 32'hB002) begin bad++; $display("FAIL fair_second got=%h expected=b002", mem_req_addr); end
        next_cycle();
        mem_rsp_valid = 1'b1;
        #1;
        total++; if (cl_rsp_valid !== 3'b100) begin bad++; $display("FAIL fair_rsp got=%b expected=100", cl_rsp_valid); end
        next_cycle();
        mem_rsp_valid = 1'b0;
        next_cycle();
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hB100) begin bad++; $display("FAIL fair_third got=%b/%h expected=1/b100", mem_req_valid, mem_req_addr); end
        mem_rsp_valid = 1'b1;
        next_cycle();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_hold_off();
        do_reset();
        hold_off = 1'b1;
        set_client(0, 32'hC000, 2'd1, 4'd2);
        next_cycle();
        cl_req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++; if (mem_req_valid !== 1'b0 || arb_idle !== 1'b0) begin bad++; $display("FAIL hold_block got=%b/%b expected=0/0", mem_req_valid, arb_idle); end
            next_cycle();
        end
        hold_off = 1'b0;
        next_cycle();
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hC000) begin bad++; $display("FAIL hold_release got=%b/%h expected=1/c000", mem_req_valid, mem_req_addr); end
        mem_rsp_valid = 1'b1;
        next_cycle();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_spurious();
        do_reset();
        set_client(0, 32'hD000, 2'd3, 4'd7);
        next_cycle();
        cl_req_valid = '0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        mem_rsp_valid = 1'b1;
        #1;
        total++; if (cl_rsp_valid !== 3'b000 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL spur_drop got=%b/%b expected=000/0", cl_rsp_valid, mem_req_valid); end
        next_cycle();
        mem_rsp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (spurious_rsp !== 1'b1) begin bad++; $display("FAIL spur_sticky got=%b expected=1", spurious_rsp); end
            next_cycle();
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        total++; if (spurious_rsp !== 1'b0) begin bad++; $display("FAIL spur_clear got=%b expected=0", spurious_rsp); end
    endtask

    task automatic test_random();
        logic [N-1:0] one;
        logic [N-1:0] exp_rsp;
        one = 1;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            cl_req_valid = '0;
            reset    = ($urandom_range(149) == 0);
            hold_off = ($urandom_range(7) == 0);
            for (int i = 0; i < N; i++)
                if (!m_pend[i] && !(m_busy && m_owner == i) && $urandom_range(3) == 0)
                    set_client(i, $urandom, TW'($urandom), 4'($urandom));
            mem_rsp_valid = m_busy ? ($urandom_range(2) == 0) : ($urandom_range(59) == 0);
            mem_rsp_load_data = rand_line();
            #1;
            exp_rsp = (m_busy && mem_rsp_valid) ? (one << m_owner) : '0;
            total++; if (mem_req_valid !== m_busy) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b expected=%b", cyc, mem_req_valid, m_busy); end
            if (m_busy) begin
                total++;
                if (mem_req_addr !== m_addr || mem_req_store_data !== m_data || mem_req_tag !== m_tag || mem_req_opcode !== m_op) begin
                    bad++; $display("FAIL rnd_fields cyc=%0d got=%h/%0d/%0d expected=%h/%0d/%0d", cyc, mem_req_addr, mem_req_tag, mem_req_opcode, m_addr, m_tag, m_op);
                end
            end
            total++; if (cl_rsp_valid !== exp_rsp) begin bad++; $display("FAIL rnd_rsp cyc=%0d got=%b expected=%b", cyc, cl_rsp_valid, exp_rsp); end
            total++; if (cl_rsp_load_data !== mem_rsp_load_data) begin bad++; $display("FAIL rnd_load cyc=%0d got=%h expected=%h", cyc, cl_rsp_load_data, mem_rsp_load_data); end
            total++; if (arb_idle !== (!m_busy && !m_pend[0] && !m_pend[1] && !m_pend[2])) begin bad++; $display("FAIL rnd_idle cyc=%0d got=%b", cyc, arb_idle); end
            total++; if (spurious_rsp !== m_spur) begin bad++; $display("FAIL rnd_spur cyc=%0d got=%b expected=%b", cyc, spurious_rsp, m_spur); end
`ifdef MEM_ARB_STATS_EN
            for (int i = 0; i < N; i++) begin
                total++; if (arb_grant_count[i*32 +: 32] !== m_gcnt[i]) begin bad++; $display("FAIL rnd_gcnt client=%0d got=%0d expected=%0d", i, arb_grant_count[i*32 +: 32], m_gcnt[i]); end
                total++; if (arb_wait_cycles[i*32 +: 32] !== m_wcnt[i]) begin bad++; $display("FAIL rnd_wcnt client=%0d got=%0d expected=%0d", i, arb_wait_cycles[i*32 +: 32], m_wcnt[i]); end
            end
`endif
            next_cycle();
        end
        reset = 1'b0; cl_req_valid = '0; mem_rsp_valid = 1'b0; hold_off = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_request();
        test_contention();
        test_fairness();
        test_hold_off();
        test_spurious();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
